// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo
//   UART transmitter with an input FIFO for the HR/SpO2 data path. The host
//   pushes words with send_en and the block shifts them out on Rs232_Tx, one
//   frame per word and LSB first, with optional parity and one or two stop
//   bits. Frames for queued words follow each other with no idle gap.
//
// Ports
//   Clk         system clock, all logic on the rising edge
//   Rst         synchronous active-high reset
//   send_en     push request, sampled every rising edge
//   data_send   word captured when a push is accepted
//   fifo_full   FIFO holds FIFO_DEPTH words
//   fifo_empty  FIFO holds no words
//   fifo_count  current FIFO occupancy
//   overflow    one-cycle pulse after a push was dropped because the FIFO was full
//   tx_busy     FSM is not in IDLE
//   Tx_Done     one-cycle pulse during the last cycle of each frame's stop period
//   Rs232_Tx    serial line, idles high, registered
module serial_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          send_en,
  input  logic [DATA_BITS-1:0]          data_send,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx_busy,
  output logic                          Tx_Done,
  output logic                          Rs232_Tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr_q, wrPtr_d;
  logic [AW-1:0]        rdPtr_q, rdPtr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 push, pop;

  // Transmitter state
  state_t               state_q;
  logic [BW-1:0]        baud_q;
  logic [3:0]           bitIdx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parBit_q;
  logic                 done_q;
  logic                 txLine_q, txLine_d;

  logic                 baudLast;
  logic                 stopLast;
  logic [DATA_BITS-1:0] headWord;
  logic                 headParity;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign tx_busy    = (state_q != ST_IDLE);
  assign Tx_Done    = done_q;
  assign Rs232_Tx   = txLine_q;

  // Fullness is judged on the registered count, so a push while full is
  // dropped even when the transmitter pops on the same edge.
  assign push = send_en && !fifo_full;

  assign baudLast = (baud_q == BAUD_LAST);
  assign stopLast = (state_q == ST_STOP) && baudLast && (bitIdx_q == STOP_LAST);

  // The transmitter takes a word either from IDLE or on the last cycle of a
  // stop period, which is what chains frames back to back.
  assign pop = !fifo_empty && ((state_q == ST_IDLE) || stopLast);

  assign headWord   = mem_q[rdPtr_q];
  assign headParity = (PARITY == 1) ? ~(^headWord) : (^headWord);

  // Next-state for the FIFO pointers and occupancy; a simultaneous push and
  // pop moves both pointers and leaves the count alone.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = send_en && fifo_full;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers; pointers wrap on their own because the depth is
  // a power of two.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array, captured at push time and never reset; stale entries are
  // unreachable once the pointers are cleared.
  always_ff @(posedge Clk) begin
    if (push && !Rst) begin
      mem_q[wrPtr_q] <= data_send;
    end
  end

  // Line level implied by the current FSM state; registered below so the
  // serial output is glitch free and sits one cycle behind the state.
  always_comb begin
    case (state_q)
      ST_START:  txLine_d = 1'b0;
      ST_DATA:   txLine_d = shift_q[0];
      ST_PARITY: txLine_d = parBit_q;
      default:   txLine_d = 1'b1;
    endcase
  end

  // Frame sequencer. The baud counter restarts at every bit boundary; bitIdx
  // counts data bits in DATA and stop bits in STOP. Parity is computed once
  // when the word is loaded, since the shifter destroys the word as it goes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      parBit_q <= 1'b0;
      done_q   <= 1'b0;
      txLine_q <= 1'b1;
    end else begin
      txLine_q <= txLine_d;
      done_q   <= stopLast;
      case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          if (pop) begin
            shift_q  <= headWord;
            parBit_q <= headParity;
            bitIdx_q <= '0;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (baudLast) begin
            baud_q  <= '0;
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (baudLast) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bitIdx_q == DATA_LAST) begin
              bitIdx_q <= '0;
              state_q  <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bitIdx_q <= bitIdx_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (baudLast) begin
            baud_q   <= '0;
            bitIdx_q <= '0;
            state_q  <= ST_STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (baudLast) begin
            baud_q <= '0;
            if (bitIdx_q == STOP_LAST) begin
              bitIdx_q <= '0;
              if (pop) begin
                shift_q  <= headWord;
                parBit_q <= headParity;
                state_q  <= ST_START;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              bitIdx_q <= bitIdx_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Testbench for serial_tx_fifo. Four instances cover the configurations used:
//   A: 8N1, BAUD_DIV=4, depth 16  (single frame, overflow, back-to-back, reset)
//   B: 8E1, BAUD_DIV=4            (even parity)
//   C: 8O1, BAUD_DIV=4            (odd parity)
//   D: 7N2, BAUD_DIV=4            (two stop bits)
module tb_serial_tx_fifo;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Reset as the DUT saw it on the last rising edge; used by the monitor so
  // it never races the task that drives Rst.
  logic rstLatched;
  always @(posedge Clk) rstLatched <= Rst;

  int errors = 0;
  int checks = 0;

  // Instance A signals
  logic       sendA = 1'b0;
  logic [7:0] dataA = '0;
  logic       fullA, emptyA, ovfA, busyA, doneA, txA;
  logic [4:0] countA;
  // Instance B signals
  logic       sendB = 1'b0;
  logic [7:0] dataB = '0;
  logic       fullB, emptyB, ovfB, busyB, doneB, txB;
  logic [4:0] countB;
  // Instance C signals
  logic       sendC = 1'b0;
  logic [7:0] dataC = '0;
  logic       fullC, emptyC, ovfC, busyC, doneC, txC;
  logic [4:0] countC;
  // Instance D signals
  logic       sendD = 1'b0;
  logic [6:0] dataD = '0;
  logic       fullD, emptyD, ovfD, busyD, doneD, txD;
  logic [4:0] countD;

  serial_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .BAUD_DIV(4), .FIFO_DEPTH(16)) dutA (
    .Clk(Clk), .Rst(Rst), .send_en(sendA), .data_send(dataA),
    .fifo_full(fullA), .fifo_empty(emptyA), .fifo_count(countA), .overflow(ovfA),
    .tx_busy(busyA), .Tx_Done(doneA), .Rs232_Tx(txA)
  );
  serial_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .BAUD_DIV(4), .FIFO_DEPTH(16)) dutB (
    .Clk(Clk), .Rst(Rst), .send_en(sendB), .data_send(dataB),
    .fifo_full(fullB), .fifo_empty(emptyB), .fifo_count(countB), .overflow(ovfB),
    .tx_busy(busyB), .Tx_Done(doneB), .Rs232_Tx(txB)
  );
  serial_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .BAUD_DIV(4), .FIFO_DEPTH(16)) dutC (
    .Clk(Clk), .Rst(Rst), .send_en(sendC), .data_send(dataC),
    .fifo_full(fullC), .fifo_empty(emptyC), .fifo_count(countC), .overflow(ovfC),
    .tx_busy(busyC), .Tx_Done(doneC), .Rs232_Tx(txC)
  );
  serial_tx_fifo #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .BAUD_DIV(4), .FIFO_DEPTH(16)) dutD (
    .Clk(Clk), .Rst(Rst), .send_en(sendD), .data_send(dataD),
    .fifo_full(fullD), .fifo_empty(emptyD), .fifo_count(countD), .overflow(ovfD),
    .tx_busy(busyD), .Tx_Done(doneD), .Rs232_Tx(txD)
  );

  // Scoreboard for instance A: expected words go in when pushed, decoded
  // frames come out of the line monitor.
  logic [7:0]  expQ[$];
  logic [7:0]  rxQ[$];
  int          rxStartQ[$];
  bit          rxCleanQ[$];
  bit          rxDoneQ[$];
  logic [39:0] lastFrameA;
  logic [39:0] monSamp;
  logic [7:0]  monWord;
  bit          monClean;
  int          monIdx = 0;
  int          monStart = 0;
  bit          monActive = 1'b0;
  int          doneCntA = 0;

  // Line monitor for instance A: a falling line starts a 40-sample capture
  // (8N1 at 4 cycles per bit); bits are read mid-bit and every bit must be
  // 4 identical samples for the frame to count as clean.
  always @(negedge Clk) begin
    if (rstLatched !== 1'b0) begin
      monActive = 1'b0;
    end else begin
      if (doneA === 1'b1) doneCntA++;
      if (monActive) begin
        monSamp[monIdx] = txA;
        if (monIdx == 39) begin
          for (int i = 0; i < 8; i++) monWord[i] = monSamp[4*(i+1)+2];
          monClean = 1'b1;
          for (int i = 0; i < 10; i++)
            if (monSamp[4*i +: 4] !== 4'h0 && monSamp[4*i +: 4] !== 4'hF) monClean = 1'b0;
          if (monSamp[3:0] !== 4'h0 || monSamp[39:36] !== 4'hF) monClean = 1'b0;
          rxQ.push_back(monWord);
          rxStartQ.push_back(monStart);
          rxCleanQ.push_back(monClean);
          rxDoneQ.push_back(doneA === 1'b1);
          lastFrameA = monSamp;
          monActive  = 1'b0;
        end
        monIdx++;
      end else if (txA === 1'b0) begin
        monActive  = 1'b1;
        monSamp[0] = 1'b0;
        monIdx     = 1;
        monStart   = cyc;
      end
    end
  end

  // Ideal line waveform, one sample per cycle at 4 cycles per bit; samples
  // past the end of the frame are idle-high.
  function automatic logic [63:0] buildFrame(input logic [8:0] w, input int nb,
                                             input int par, input int stops);
    logic [63:0] f;
    logic        bits[$];
    logic        pb;
    f  = '1;
    pb = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(w[i]);
      pb = pb ^ w[i];
    end
    if (par == 1) bits.push_back(~pb);
    if (par == 2) bits.push_back(pb);
    for (int s = 0; s < stops; s++) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++)
      for (int j = 0; j < 4; j++) f[4*k+j] = bits[k];
    return f;
  endfunction

  function automatic logic lineOf(input int which);
    case (which)
      1:       return txB;
      2:       return txC;
      3:       return txD;
      default: return txA;
    endcase
  endfunction

  function automatic logic doneOf(input int which);
    case (which)
      1:       return doneB;
      2:       return doneC;
      3:       return doneD;
      default: return doneA;
    endcase
  endfunction

  // Waits (bounded) for a start bit on the chosen line, then records len
  // samples plus how Tx_Done behaved across them.
  task automatic captureFrame(input int which, input int len, output logic [63:0] v,
                              output bit timedOut, output int doneHighs, output bit doneLast);
    int n;
    v = '1; timedOut = 1'b0; doneHighs = 0; doneLast = 1'b0; n = 0;
    while (lineOf(which) !== 1'b0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 100) begin
      timedOut = 1'b1;
      return;
    end
    for (int i = 0; i < len; i++) begin
      v[i] = lineOf(which);
      if (doneOf(which) === 1'b1) doneHighs++;
      if (i == len - 1) doneLast = (doneOf(which) === 1'b1);
      @(negedge Clk);
    end
  endtask

  task automatic waitRxA(input int n, input int limit, output bit ok);
    int k;
    k = 0;
    while (rxQ.size() < n && k < limit) begin
      @(negedge Clk);
      k++;
    end
    @(negedge Clk);
    ok = (rxQ.size() >= n);
  endtask

  task automatic clearScoreboard();
    expQ.delete(); rxQ.delete(); rxStartQ.delete(); rxCleanQ.delete(); rxDoneQ.delete();
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++; if (txA !== 1'b1)    begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", txA); end
    checks++; if (busyA !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busyA); end
    checks++; if (doneA !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", doneA); end
    checks++; if (ovfA !== 1'b0)   begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", ovfA); end
    checks++; if (countA !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", countA); end
    checks++; if (emptyA !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", emptyA); end
    checks++; if (fullA !== 1'b0)  begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", fullA); end
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_single_frame();
    int          acceptCyc, doneBefore;
    bit          ok;
    logic [63:0] expF;
    logic [7:0]  got;
    clearScoreboard();
    doneBefore = doneCntA;
    sendA = 1'b1; dataA = 8'h55; expQ.push_back(8'h55);
    @(posedge Clk); @(negedge Clk);
    sendA = 1'b0; dataA = 8'hFF;
    acceptCyc = cyc;
    waitRxA(1, 200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL single_timeout: got %0d frames expected 1", rxQ.size());
    end else begin
      expF = buildFrame(9'h055, 8, 0, 1);
      got  = rxQ.pop_front();
      checks++; if (got !== expQ.pop_front()) begin errors++; $display("[TB] FAIL single_word: got %h expected 55", got); end
      checks++; if (lastFrameA !== expF[39:0]) begin errors++; $display("[TB] FAIL single_wave: got %h expected %h", lastFrameA, expF[39:0]); end
      checks++; if (rxStartQ[0] - acceptCyc != 2) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 2", rxStartQ[0] - acceptCyc); end
      checks++; if (rxDoneQ[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_done_pos: got %b expected 1", rxDoneQ[0]); end
    end
    repeat (4) @(negedge Clk);
    checks++; if (doneCntA - doneBefore != 1) begin errors++; $display("[TB] FAIL single_done_count: got %0d expected 1", doneCntA - doneBefore); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %b expected 0", busyA); end
  endtask

  task automatic test_parity();
    int          whichTab[3] = '{1, 2, 1};
    logic [7:0]  dataTab[3]  = '{8'h03, 8'h03, 8'h07};
    logic        parTab[3]   = '{1'b0, 1'b1, 1'b1};
    int          modeTab[3]  = '{2, 1, 2};
    logic [63:0] v, expF;
    bit          to, dl;
    int          dh;
    for (int t = 0; t < 3; t++) begin
      if (whichTab[t] == 1) begin sendB = 1'b1; dataB = dataTab[t]; end
      else                  begin sendC = 1'b1; dataC = dataTab[t]; end
      @(posedge Clk); @(negedge Clk);
      sendB = 1'b0; sendC = 1'b0; dataB = 8'h00; dataC = 8'h00;
      captureFrame(whichTab[t], 44, v, to, dh, dl);
      expF = buildFrame({1'b0, dataTab[t]}, 8, modeTab[t], 1);
      checks++;
      if (to) begin
        errors++; $display("[TB] FAIL parity_timeout[%0d]: got no start expected frame", t);
      end else begin
        checks++; if (v[37] !== parTab[t]) begin errors++; $display("[TB] FAIL parity_bit[%0d]: got %b expected %b", t, v[37], parTab[t]); end
        checks++; if (v !== expF) begin errors++; $display("[TB] FAIL parity_wave[%0d]: got %h expected %h", t, v, expF); end
        checks++; if (dh != 1 || !dl) begin errors++; $display("[TB] FAIL parity_done[%0d]: got %0d pulses last=%b expected 1 last=1", t, dh, dl); end
      end
      repeat (3) @(negedge Clk);
    end
  endtask

  task automatic test_overflow();
    int         ovfHigh;
    bit         ok;
    logic [7:0] got, expw;
    clearScoreboard();
    ovfHigh = 0;
    for (int k = 0; k < 18; k++) begin
      sendA = 1'b1;
      dataA = 8'(8'h30 + 5 * k);
      if (k < 17) expQ.push_back(dataA);
      @(posedge Clk); @(negedge Clk);
      if (ovfA === 1'b1) ovfHigh++;
      if (k == 15) begin
        checks++; if (fullA !== 1'b0) begin errors++; $display("[TB] FAIL ovf_full16: got %b expected 0", fullA); end
      end
      if (k == 16) begin
        checks++; if (fullA !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full17: got %b expected 1", fullA); end
        checks++; if (countA !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count17: got %0d expected 16", countA); end
      end
      if (k == 17) begin
        checks++; if (ovfA !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pulse: got %b expected 1", ovfA); end
      end
    end
    sendA = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      if (ovfA === 1'b1) ovfHigh++;
    end
    checks++; if (ovfHigh != 1) begin errors++; $display("[TB] FAIL ovf_pulse_count: got %0d expected 1", ovfHigh); end
    waitRxA(17, 17 * 40 + 200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ovf_frames: got %0d expected 17", rxQ.size()); end
    while (rxQ.size() > 0 && expQ.size() > 0) begin
      got  = rxQ.pop_front();
      expw = expQ.pop_front();
      checks++; if (got !== expw) begin errors++; $display("[TB] FAIL ovf_word: got %h expected %h", got, expw); end
      checks++; if (rxCleanQ.pop_front() !== 1'b1) begin errors++; $display("[TB] FAIL ovf_clean: got 0 expected 1 for %h", expw); end
    end
    repeat (80) @(negedge Clk);
    checks++; if (rxQ.size() != 0) begin errors++; $display("[TB] FAIL ovf_extra_frame: got %0d expected 0", rxQ.size()); end
    checks++; if (emptyA !== 1'b1) begin errors++; $display("[TB] FAIL ovf_empty_end: got %b expected 1", emptyA); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[3] = '{8'hA1, 8'h3C, 8'hF0};
    int         doneBefore;
    bit         ok;
    logic [7:0] got, expw;
    clearScoreboard();
    doneBefore = doneCntA;
    for (int k = 0; k < 3; k++) begin
      sendA = 1'b1; dataA = words[k]; expQ.push_back(words[k]);
      @(posedge Clk); @(negedge Clk);
    end
    sendA = 1'b0; dataA = 8'h00;
    waitRxA(3, 3 * 40 + 200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_frames: got %0d expected 3", rxQ.size()); end
    for (int k = 1; k < rxStartQ.size(); k++) begin
      checks++; if (rxStartQ[k] - rxStartQ[k-1] != 40) begin errors++; $display("[TB] FAIL b2b_gap[%0d]: got %0d expected 40", k, rxStartQ[k] - rxStartQ[k-1]); end
    end
    while (rxQ.size() > 0 && expQ.size() > 0) begin
      got  = rxQ.pop_front();
      expw = expQ.pop_front();
      checks++; if (got !== expw) begin errors++; $display("[TB] FAIL b2b_word: got %h expected %h", got, expw); end
    end
    repeat (5) @(negedge Clk);
    checks++; if (doneCntA - doneBefore != 3) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 3", doneCntA - doneBefore); end
    checks++; if (emptyA !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty: got %b expected 1", emptyA); end
  endtask

  task automatic test_stop_bits();
    logic [63:0] v, expF;
    bit          to, dl;
    int          dh;
    sendD = 1'b1; dataD = 7'h41;
    @(posedge Clk); @(negedge Clk);
    sendD = 1'b0; dataD = 7'h00;
    captureFrame(3, 40, v, to, dh, dl);
    expF = buildFrame(9'h041, 7, 0, 2);
    checks++;
    if (to) begin
      errors++; $display("[TB] FAIL stop2_timeout: got no start expected frame");
    end else begin
      checks++; if (v !== expF) begin errors++; $display("[TB] FAIL stop2_wave: got %h expected %h", v, expF); end
      checks++; if (v[39:32] !== 8'hFF) begin errors++; $display("[TB] FAIL stop2_high: got %h expected ff", v[39:32]); end
      checks++; if (dh != 1 || !dl) begin errors++; $display("[TB] FAIL stop2_done: got %0d pulses last=%b expected 1 last=1", dh, dl); end
    end
    repeat (3) @(negedge Clk);
    checks++; if (txD !== 1'b1 || busyD !== 1'b0) begin errors++; $display("[TB] FAIL stop2_idle: got tx=%b busy=%b expected tx=1 busy=0", txD, busyD); end
  endtask

  task automatic test_reset_mid_frame();
    bit lowSeen, doneSeen;
    clearScoreboard();
    for (int k = 0; k < 4; k++) begin
      sendA = 1'b1; dataA = 8'(8'h11 * (k + 1));
      @(posedge Clk); @(negedge Clk);
    end
    sendA = 1'b0;
    repeat (8) @(negedge Clk);
    checks++; if (countA !== 5'd3) begin errors++; $display("[TB] FAIL rstmid_queued: got %0d expected 3", countA); end
    Rst = 1'b1;
    @(posedge Clk); @(negedge Clk);
    Rst = 1'b0;
    checks++; if (txA !== 1'b1)    begin errors++; $display("[TB] FAIL rstmid_tx: got %b expected 1", txA); end
    checks++; if (countA !== 5'd0) begin errors++; $display("[TB] FAIL rstmid_count: got %0d expected 0", countA); end
    checks++; if (busyA !== 1'b0)  begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busyA); end
    checks++; if (doneA !== 1'b0)  begin errors++; $display("[TB] FAIL rstmid_done: got %b expected 0", doneA); end
    lowSeen = 1'b0; doneSeen = 1'b0;
    repeat (150) begin
      @(negedge Clk);
      if (txA !== 1'b1) lowSeen = 1'b1;
      if (doneA !== 1'b0) doneSeen = 1'b1;
    end
    checks++; if (lowSeen)  begin errors++; $display("[TB] FAIL rstmid_line_quiet: got activity expected idle high"); end
    checks++; if (doneSeen) begin errors++; $display("[TB] FAIL rstmid_no_done: got pulse expected none"); end
    checks++; if (rxQ.size() != 0) begin errors++; $display("[TB] FAIL rstmid_frames: got %0d expected 0", rxQ.size()); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_overflow();
    test_back_to_back();
    test_stop_bits();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
